aes_word_loader: RTL and testbench
==================================

Name: aes_word_loader

Overview:
- Upstream/downstream I/O stage for the AES controller.
- Assembles the 128-bit key and 128-bit ciphertext from a 32-bit write port, then pulses io_ready to start the controller.
- Waits for a fresh aes_ready, captures the 128-bit msg_de result, and streams it back out as four 32-bit words on a valid/ready read port.
- Sits between the host-side bus bridge and the AES controller.

Parameters:
- TIMEOUT_CYCLES, 131072, max cycles spent in WAIT_AES before abort (only with AES_LOADER_TIMEOUT_EN).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_valid  in  1  write word present.
- wr_ready  out  1  loader accepts write this cycle.
- wr_sel  in  1  0 = key word, 1 = message word.
- wr_data  in  32  write word.
- key  out  128  assembled key to controller.
- msg_en  out  128  assembled message to controller.
- io_ready  out  1  one-cycle start pulse to controller.
- aes_ready  in  1  controller done level.
- msg_de  in  128  controller result.
- rd_valid  out  1  result word available.
- rd_ready  in  1  consumer takes word.
- rd_data  out  32  result word.
- busy  out  1  high in any state except LOAD.
- err  out  1  sticky error flag.

Behaviour:
- Clock and reset:
  - Single clock clk; reset is synchronous and active-high, named reset.
  - Reset forces state LOAD and clears key_cnt, msg_cnt, rd_cnt, the timeout counter, key, msg_en, the result register and err.
  - Output values in reset: io_ready=0, rd_valid=0, rd_data=0, busy=0, wr_ready=1.
  - Reset asserted in any state aborts the operation immediately; no io_ready pulse and no rd_valid on the following cycle.
- Word order, all 128-bit fields: first word goes to [127:96], then [95:64], [63:32], last to [31:0]. Unload uses the same order.
- LOAD:
  - wr_ready=1.
  - A write occurs on wr_valid&&wr_ready. Its word is stored in the field selected by wr_sel at index key_cnt/msg_cnt, and that 3-bit counter increments.
  - Write to a field whose counter is already 4: word dropped, counter unchanged, err set.
  - When both counters equal 4 at a clock edge, go to START.
  - If the fourth word of the second field is written at cycle N, the state is START at N+1.
- START:
  - io_ready=1 for exactly one cycle; wr_ready=0.
  - Clear the armed flag.
  - Go to WAIT_AES.
- WAIT_AES:
  - wr_ready=0.
  - A sampled aes_ready=0 sets armed.
  - aes_ready=1 while armed: capture msg_de into the result register, set rd_cnt=0, go to UNLOAD.
  - aes_ready=1 while not armed (stale done from the previous operation) is ignored.
  - key and msg_en stay stable throughout.
- UNLOAD:
  - rd_valid=1; rd_data = result word rd_cnt.
  - rd_data holds while rd_valid && !rd_ready.
  - On rd_ready, rd_cnt increments.
  - On acceptance of word 3: clear key_cnt and msg_cnt, go to LOAD. rd_valid is 0 the next cycle.
  - key and msg_en are not cleared; they are simply overwritten by the next load.
- Simultaneous events:
  - wr_valid outside LOAD: ignored, no err.
  - In the same cycle: fourth key word and fourth msg word cannot both arrive (one write port). A write to a full field in the cycle the other field completes: the drop and err apply, and the transition to START still happens.
- err:
  - Sticky; cleared only by reset.
  - Does not block operation.

Optional Feature:
- AES_LOADER_TIMEOUT_EN, defined:
  - A 17-bit counter clears on entry to WAIT_AES and increments each cycle in WAIT_AES.
  - If it reaches TIMEOUT_CYCLES-1 without a capture: set err, clear key_cnt/msg_cnt, return to LOAD, no UNLOAD.
- Not defined:
  - No counter is built; WAIT_AES waits indefinitely.
  - err is driven only by dropped writes.

Test Plan:
- Reset, then write key words 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F (wr_sel=0) and msg words 0x69C4E0D8, 0x6A7B0430, 0xD8CDB780, 0x70B4C55A (wr_sel=1) -> key=0x000102030405060708090A0B0C0D0E0F, msg_en=0x69C4E0D86A7B0430D8CDB78070B4C55A, single io_ready pulse one cycle after the last write, busy=1.
- From WAIT_AES, drive aes_ready=0 for 3 cycles, then 1 with msg_de=0x00112233445566778899AABBCCDDEEFF, rd_ready=1 -> rd_data sequence 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on 4 consecutive cycles; LOAD after the last word, busy=0.
- Hold aes_ready=1 continuously from START onward -> no capture and no rd_valid; then drop aes_ready for 1 cycle and raise it -> capture on the rising sample.
- During UNLOAD, toggle rd_ready 0,1,0,0,1,1,1 -> each word is held stable while rd_ready=0; exactly 4 words are delivered, in order.
- Write a fifth key word 0xDEADBEEF after 4 key words -> err=1, key unchanged, operation completes normally once 4 msg words arrive.
- With AES_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16, keep aes_ready=0 after START -> return to LOAD after 16 WAIT_AES cycles, err=1, rd_valid never asserted. Separately, assert reset mid-UNLOAD -> rd_valid=0 and busy=0 on the next cycle.

Source files
------------

// File: rtl/aes_word_loader_if.sv
// Host-side bus between the bridge and the AES word loader:
// a 32-bit write port for key/message words and a 32-bit valid/ready result read port.
interface aes_word_loader_if;
    logic        wr_valid;
    logic        wr_ready;
    logic        wr_sel;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;

    modport master (
        output wr_valid, wr_sel, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_sel, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/aes_word_loader.sv
// I/O stage for the AES controller: assembles key/ciphertext words, starts the core, streams the result back.
// Optional WAIT_AES abort timer enabled by defining AES_LOADER_TIMEOUT_EN.
//
// state    | meaning
// LOAD     | accepting key/message words until both fields hold 4 words
// START    | one-cycle io_ready pulse to the controller
// WAIT_AES | waiting for a fresh (low-then-high) aes_ready
// UNLOAD   | presenting the four result words on the read port
module aes_word_loader
`ifdef AES_LOADER_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 131072
)
`endif
(
    input  logic                    clk,
    input  logic                    reset,
    aes_word_loader_if.slave        bus,
    output logic [127:0]            key,
    output logic [127:0]            msg_en,
    output logic                    io_ready,
    input  logic                    aes_ready,
    input  logic [127:0]            msg_de,
    output logic                    busy,
    output logic                    err
);

    typedef enum logic [1:0] {
        LOAD     = 2'd0,
        START    = 2'd1,
        WAIT_AES = 2'd2,
        UNLOAD   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        key_cnt;
    logic [2:0]        msg_cnt;
    logic [2:0]        key_cnt_nxt;
    logic [2:0]        msg_cnt_nxt;
    logic [1:0]        rd_cnt;
    logic              armed;
    logic              key_wr;
    logic              msg_wr;
    logic              drop;
    logic              capture;
    logic [3:0][31:0]  key_q;
    logic [3:0][31:0]  msg_q;
    logic [3:0][31:0]  result_q;

`ifdef AES_LOADER_TIMEOUT_EN
    localparam logic [16:0] TO_LAST = 17'(TIMEOUT_CYCLES - 1);
    logic [16:0]       to_cnt;
    logic              timeout_hit;
`endif

    assign key    = key_q;
    assign msg_en = msg_q;

    always_comb begin
        state_nxt    = state;
        key_cnt_nxt  = key_cnt;
        msg_cnt_nxt  = msg_cnt;
        key_wr       = 1'b0;
        msg_wr       = 1'b0;
        drop         = 1'b0;
        capture      = 1'b0;
`ifdef AES_LOADER_TIMEOUT_EN
        timeout_hit  = 1'b0;
`endif
        bus.wr_ready = (state == LOAD);
        bus.rd_valid = (state == UNLOAD);
        bus.rd_data  = '0;
        io_ready     = (state == START);
        busy         = (state != LOAD);

        case (state)
            LOAD: begin
                if (bus.wr_valid) begin
                    if (!bus.wr_sel) begin
                        if (key_cnt == 3'd4) begin
                            drop = 1'b1;
                        end else begin
                            key_wr      = 1'b1;
                            key_cnt_nxt = key_cnt + 3'd1;
                        end
                    end else begin
                        if (msg_cnt == 3'd4) begin
                            drop = 1'b1;
                        end else begin
                            msg_wr      = 1'b1;
                            msg_cnt_nxt = msg_cnt + 3'd1;
                        end
                    end
                end
                // Decide on post-write counts so START follows the final write by one cycle.
                if (key_cnt_nxt == 3'd4 && msg_cnt_nxt == 3'd4) begin
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt = WAIT_AES;
            end
            WAIT_AES: begin
                if (aes_ready && armed) begin
                    capture   = 1'b1;
                    state_nxt = UNLOAD;
                end
`ifdef AES_LOADER_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    timeout_hit = 1'b1;
                    key_cnt_nxt = 3'd0;
                    msg_cnt_nxt = 3'd0;
                    state_nxt   = LOAD;
                end
`endif
            end
            UNLOAD: begin
                bus.rd_data = result_q[~rd_cnt];
                if (bus.rd_ready && rd_cnt == 2'd3) begin
                    key_cnt_nxt = 3'd0;
                    msg_cnt_nxt = 3'd0;
                    state_nxt   = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= LOAD;
            key_cnt  <= 3'd0;
            msg_cnt  <= 3'd0;
            rd_cnt   <= 2'd0;
            armed    <= 1'b0;
            key_q    <= '0;
            msg_q    <= '0;
            result_q <= '0;
            err      <= 1'b0;
`ifdef AES_LOADER_TIMEOUT_EN
            to_cnt   <= '0;
`endif
        end else begin
            state   <= state_nxt;
            key_cnt <= key_cnt_nxt;
            msg_cnt <= msg_cnt_nxt;

            // Word index 0 lands in the most significant 32 bits.
            if (key_wr) begin
                key_q[~key_cnt[1:0]] <= bus.wr_data;
            end
            if (msg_wr) begin
                msg_q[~msg_cnt[1:0]] <= bus.wr_data;
            end
            if (drop) begin
                err <= 1'b1;
            end

            // A done level left over from the previous operation must drop before it counts.
            if (state == START) begin
                armed <= 1'b0;
            end else if (state == WAIT_AES && !aes_ready) begin
                armed <= 1'b1;
            end

            if (capture) begin
                result_q <= msg_de;
                rd_cnt   <= 2'd0;
            end else if (state == UNLOAD && bus.rd_ready) begin
                rd_cnt <= rd_cnt + 2'd1;
            end

`ifdef AES_LOADER_TIMEOUT_EN
            if (state == START) begin
                to_cnt <= '0;
            end else if (state == WAIT_AES) begin
                to_cnt <= to_cnt + 17'd1;
            end
            if (timeout_hit) begin
                err <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_aes_word_loader.sv
// Directed, table-driven bench for aes_word_loader: full load/start/capture/unload operations
// plus hand-written sequences for stale done, read back-pressure, dropped writes and mid-unload reset.
module tb_aes_word_loader;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] key;
    logic [127:0] msg_en;
    logic         io_ready;
    logic         aes_ready;
    logic [127:0] msg_de;
    logic         busy;
    logic         err;

    int tests = 0;
    int fails = 0;

    aes_word_loader_if bus_if();

`ifdef AES_LOADER_TIMEOUT_EN
    aes_word_loader #(.TIMEOUT_CYCLES(16)) dut (
`else
    aes_word_loader dut (
`endif
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if),
        .key       (key),
        .msg_en    (msg_en),
        .io_ready  (io_ready),
        .aes_ready (aes_ready),
        .msg_de    (msg_de),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][31:0] kw;       // kw[3] is written first
        logic [3:0][31:0] mw;
        logic             interleave;
        logic [127:0]     de;
        logic [127:0]     exp_key;
        logic [127:0]     exp_msg;
        logic [3:0][31:0] exp_rd;   // exp_rd[3] is read first
    } vec_t;

    vec_t vecs[3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic write_word(input logic sel, input logic [31:0] data);
        bus_if.wr_valid = 1'b1;
        bus_if.wr_sel   = sel;
        bus_if.wr_data  = data;
        tick();
        bus_if.wr_valid = 1'b0;
    endtask

    // Writes all eight words of vector i, checks the start pulse, returns just inside WAIT_AES.
    task automatic load_and_check(input int i);
        for (int j = 0; j < 4; j++) begin
            if (vecs[i].interleave) begin
                write_word(1'b0, vecs[i].kw[3-j]);
                write_word(1'b1, vecs[i].mw[3-j]);
            end else begin
                write_word(1'b0, vecs[i].kw[3-j]);
            end
        end
        if (!vecs[i].interleave) begin
            for (int j = 0; j < 4; j++) begin
                check("io_ready_low_during_load", io_ready, 1'b0);
                write_word(1'b1, vecs[i].mw[3-j]);
            end
        end
        check("io_ready_pulse", io_ready, 1'b1);
        check("busy_in_start", busy, 1'b1);
        check("wr_ready_in_start", bus_if.wr_ready, 1'b0);
        check("key", key, vecs[i].exp_key);
        check("msg_en", msg_en, vecs[i].exp_msg);
        tick();
        check("io_ready_single", io_ready, 1'b0);
    endtask

    // From WAIT_AES entry: done low for 3 cycles, then high; drain with rd_ready held high.
    task automatic finish_op(input logic [127:0] de, input logic [3:0][31:0] exp_rd);
        aes_ready = 1'b0;
        repeat (3) begin
            tick();
            check("rd_valid_while_waiting", bus_if.rd_valid, 1'b0);
        end
        aes_ready       = 1'b1;
        msg_de          = de;
        bus_if.rd_ready = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            check("rd_valid_unload", bus_if.rd_valid, 1'b1);
            check("rd_data", bus_if.rd_data, exp_rd[3-k]);
            tick();
        end
        check("rd_valid_after_last", bus_if.rd_valid, 1'b0);
        check("busy_after_last", busy, 1'b0);
        check("wr_ready_after_last", bus_if.wr_ready, 1'b1);
        bus_if.rd_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  pat;
        int          idx;

        vecs[0].kw         = {32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
        vecs[0].mw         = {32'h69C4E0D8, 32'h6A7B0430, 32'hD8CDB780, 32'h70B4C55A};
        vecs[0].interleave = 1'b0;
        vecs[0].de         = 128'h00112233445566778899AABBCCDDEEFF;
        vecs[0].exp_key    = 128'h000102030405060708090A0B0C0D0E0F;
        vecs[0].exp_msg    = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
        vecs[0].exp_rd     = {32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};

        vecs[1].kw         = {32'h2B7E1516, 32'h28AED2A6, 32'hABF71588, 32'h09CF4F3C};
        vecs[1].mw         = {32'h3243F6A8, 32'h885A308D, 32'h313198A2, 32'hE0370734};
        vecs[1].interleave = 1'b0;
        vecs[1].de         = 128'h3925841D02DC09FBDC118597196A0B32;
        vecs[1].exp_key    = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
        vecs[1].exp_msg    = 128'h3243F6A8885A308D313198A2E0370734;
        vecs[1].exp_rd     = {32'h3925841D, 32'h02DC09FB, 32'hDC118597, 32'h196A0B32};

        vecs[2].kw         = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        vecs[2].mw         = {32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};
        vecs[2].interleave = 1'b1;
        vecs[2].de         = 128'hFEDCBA98765432100123456789ABCDEF;
        vecs[2].exp_key    = 128'h11111111222222223333333344444444;
        vecs[2].exp_msg    = 128'hAAAAAAAABBBBBBBBCCCCCCCCDDDDDDDD;
        vecs[2].exp_rd     = {32'hFEDCBA98, 32'h76543210, 32'h01234567, 32'h89ABCDEF};

        reset           = 1'b1;
        aes_ready       = 1'b0;
        msg_de          = '0;
        bus_if.wr_valid = 1'b0;
        bus_if.wr_sel   = 1'b0;
        bus_if.wr_data  = '0;
        bus_if.rd_ready = 1'b0;
        tick();
        tick();
        check("reset_wr_ready", bus_if.wr_ready, 1'b1);
        check("reset_rd_valid", bus_if.rd_valid, 1'b0);
        check("reset_rd_data", bus_if.rd_data, 32'h0);
        check("reset_busy", busy, 1'b0);
        check("reset_io_ready", io_ready, 1'b0);
        check("reset_err", err, 1'b0);
        check("reset_key", key, 128'h0);
        check("reset_msg_en", msg_en, 128'h0);
        reset = 1'b0;
        tick();

        // Full operations; aes_ready is left high between them, so each start also sees a stale done.
        for (int i = 0; i < 3; i++) begin
            load_and_check(i);
            finish_op(vecs[i].de, vecs[i].exp_rd);
        end
        check("err_clean_ops", err, 1'b0);

        // Stale done: aes_ready high from START on must not capture.
        aes_ready = 1'b1;
        load_and_check(0);
        repeat (5) begin
            tick();
            check("stale_no_rd_valid", bus_if.rd_valid, 1'b0);
            check("stale_busy", busy, 1'b1);
        end
        aes_ready = 1'b0;
        tick();
        aes_ready = 1'b1;
        msg_de    = vecs[1].de;
        tick();
        check("rearm_capture_rd_valid", bus_if.rd_valid, 1'b1);

        // Read back-pressure pattern 0,1,0,0,1,1,1 (pat[0] applied first).
        pat = 7'b1110010;
        idx = 0;
        for (int c = 0; c < 7; c++) begin
            bus_if.rd_ready = pat[c];
            check("bp_rd_valid", bus_if.rd_valid, 1'b1);
            check("bp_rd_data", bus_if.rd_data, vecs[1].exp_rd[3-idx]);
            tick();
            if (pat[c]) idx++;
        end
        bus_if.rd_ready = 1'b0;
        check("bp_rd_valid_done", bus_if.rd_valid, 1'b0);
        check("bp_busy_done", busy, 1'b0);

        // Fifth key word is dropped and flags err; operation still completes.
        check("err_before_drop", err, 1'b0);
        for (int j = 0; j < 4; j++) write_word(1'b0, vecs[1].kw[3-j]);
        write_word(1'b0, 32'hDEADBEEF);
        check("drop_err", err, 1'b1);
        check("drop_key_unchanged", key, vecs[1].exp_key);
        check("drop_still_load", busy, 1'b0);
        for (int j = 0; j < 4; j++) write_word(1'b1, vecs[1].mw[3-j]);
        check("drop_io_ready", io_ready, 1'b1);
        check("drop_key", key, vecs[1].exp_key);
        check("drop_msg_en", msg_en, vecs[1].exp_msg);
        tick();
        finish_op(vecs[1].de, vecs[1].exp_rd);
        check("err_sticky", err, 1'b1);

        // Write outside LOAD is ignored and raises no err (err already 1 here, so check key instead).
        load_and_check(2);
        write_word(1'b0, 32'h55555555);
        check("write_outside_load_key", key, vecs[2].exp_key);
        aes_ready = 1'b0;
        tick();
        aes_ready = 1'b1;
        msg_de    = vecs[2].de;
        tick();
        bus_if.rd_ready = 1'b0;
        check("pre_reset_rd_valid", bus_if.rd_valid, 1'b1);
        check("pre_reset_rd_data", bus_if.rd_data, 32'hFEDCBA98);
        tick();
        check("hold_rd_data", bus_if.rd_data, 32'hFEDCBA98);

        // Reset mid-UNLOAD aborts immediately.
        reset = 1'b1;
        tick();
        check("mid_reset_rd_valid", bus_if.rd_valid, 1'b0);
        check("mid_reset_busy", busy, 1'b0);
        check("mid_reset_rd_data", bus_if.rd_data, 32'h0);
        check("mid_reset_err", err, 1'b0);
        reset     = 1'b0;
        aes_ready = 1'b0;
        tick();

        // After reset the loader must need a complete fresh load.
        load_and_check(0);
        finish_op(vecs[0].de, vecs[0].exp_rd);

`ifdef AES_LOADER_TIMEOUT_EN
        load_and_check(1);
        aes_ready = 1'b0;
        for (int c = 0; c < 16; c++) begin
            check("to_busy_waiting", busy, 1'b1);
            check("to_no_rd_valid", bus_if.rd_valid, 1'b0);
            tick();
        end
        check("to_back_in_load", busy, 1'b0);
        check("to_err", err, 1'b1);
        check("to_rd_valid", bus_if.rd_valid, 1'b0);
        load_and_check(2);
        finish_op(vecs[2].de, vecs[2].exp_rd);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
